// File: rtl/seg7_value_display.sv
// rtl/seg7_value_display.sv - multi-channel signed value to seven-segment display engine
module seg7_value_display #(
  parameter int DATA_W      = 16,
  parameter int CHANNELS    = 3,
  parameter int DIGITS      = 6,
  parameter int REFRESH_DIV = 5_000_000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [CHANNELS*DATA_W-1:0]                      sample_data,
  input  logic                                            sample_valid,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] chan_sel,
  input  logic                                            peak_mode,
  input  logic                                            peak_clr,
  output logic [DIGITS*8-1:0]                             hex,
  output logic                                            refresh_pulse,
  output logic                                            busy,
  output logic                                            overflow
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BCD_N = (DATA_W + 2) / 3;
  localparam int BCD_W = 4 * BCD_N;
  localparam int EXT_N = (BCD_N > DIGITS) ? BCD_N : DIGITS;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [7:0] SEG_MASK = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] SEG_DASH = 8'h40 ^ SEG_MASK;

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 pulse_q;
  logic [DATA_W-1:0]    live_q [CHANNELS];
  logic [DATA_W-1:0]    live_d [CHANNELS];
  logic [DATA_W-1:0]    peak_q [CHANNELS];
  logic [DATA_W-1:0]    peak_d [CHANNELS];
  logic [DATA_W-1:0]    sel_val;
  logic                 sign_q, sign_d;
  logic [DATA_W-1:0]    mag_q, mag_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, adj;
  logic [BIT_W-1:0]     bits_q, bits_d;
  logic [DIGITS*8-1:0]  hex_q, hex_d, fmt_hex;
  logic                 ovf_q, ovf_d, fmt_ovf;
  logic [4*EXT_N-1:0]   ext;
  int                   msd_idx;

  function automatic logic [DATA_W-1:0] mag_of(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0: p = 8'h3F;
      4'd1: p = 8'h06;
      4'd2: p = 8'h5B;
      4'd3: p = 8'h4F;
      4'd4: p = 8'h66;
      4'd5: p = 8'h6D;
      4'd6: p = 8'h7D;
      4'd7: p = 8'h07;
      4'd8: p = 8'h7F;
      4'd9: p = 8'h6F;
      default: p = 8'h00;
    endcase
    return p ^ SEG_MASK;
  endfunction

  // Pulse is registered one count early so it coincides with count REFRESH_DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= (cnt_q == CNT_W'(REFRESH_DIV - 2));
      cnt_q   <= (cnt_q == CNT_W'(REFRESH_DIV - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      live_d[k] = live_q[k];
      peak_d[k] = peak_clr ? '0 : peak_q[k];
      if (sample_valid) begin
        live_d[k] = sample_data[k*DATA_W +: DATA_W];
        if (mag_of(sample_data[k*DATA_W +: DATA_W]) > mag_of(peak_d[k]))
          peak_d[k] = sample_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (!rst_n) begin
        live_q[k] <= '0;
        peak_q[k] <= '0;
      end else begin
        live_q[k] <= live_d[k];
        peak_q[k] <= peak_d[k];
      end
    end
  end

  // Next-state values are selected so a sample landing on the pulse edge is included.
  always_comb begin
    sel_val = peak_mode ? peak_d[0] : live_d[0];
    for (int k = 1; k < CHANNELS; k++)
      if (chan_sel == SEL_W'(k)) sel_val = peak_mode ? peak_d[k] : live_d[k];
  end

  always_comb begin
    ext     = (4*EXT_N)'(bcd_q);
    fmt_ovf = 1'b0;
    msd_idx = 0;
    fmt_hex = {DIGITS{SEG_MASK}};
    for (int i = DIGITS - 1; i < EXT_N; i++)
      if (ext[i*4 +: 4] != 4'd0) fmt_ovf = 1'b1;
    for (int i = 0; i < DIGITS - 1; i++)
      if (ext[i*4 +: 4] != 4'd0) msd_idx = i;
    for (int i = 0; i < DIGITS - 1; i++)
      if (i <= msd_idx) fmt_hex[i*8 +: 8] = seg7(ext[i*4 +: 4]);
    if (sign_q) fmt_hex[(msd_idx + 1)*8 +: 8] = SEG_DASH;
    if (fmt_ovf) fmt_hex = {DIGITS{SEG_DASH}};
  end

  always_comb begin
    adj = bcd_q;
    for (int n = 0; n < BCD_N; n++)
      if (bcd_q[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    bits_d  = bits_q;
    hex_d   = hex_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (pulse_q) begin
          state_d = SHIFT;
          sign_d  = sel_val[DATA_W-1];
          mag_d   = mag_of(sel_val);
          bcd_d   = '0;
          bits_d  = BIT_W'(DATA_W);
        end
      end
      SHIFT: begin
        bcd_d  = {adj[BCD_W-2:0], mag_q[DATA_W-1]};
        mag_d  = mag_q << 1;
        bits_d = bits_q - 1'b1;
        if (bits_q == BIT_W'(1)) state_d = FORMAT;
      end
      FORMAT: begin
        hex_d   = fmt_hex;
        ovf_d   = fmt_ovf;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      bits_q  <= '0;
      hex_q   <= {DIGITS{SEG_MASK}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      bits_q  <= bits_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
    end
  end

  assign hex           = hex_q;
  assign refresh_pulse = pulse_q;
  assign busy          = (state_q != IDLE);
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_seg7_value_display.sv
// tb/tb_seg7_value_display.sv - randomized self-checking bench for seg7_value_display
module tb_seg7_value_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] sample_data;
  logic        sample_valid, peak_mode, peak_clr;
  logic [1:0]  chan_sel;
  logic [47:0] hex;
  logic        refresh_pulse, busy, overflow;

  logic [47:0] d4_data;
  logic        d4_valid, d4_pmode, d4_pclr;
  logic [1:0]  d4_sel;
  logic [31:0] d4_hex;
  logic        d4_pulse, d4_busy, d4_ovf;

  int n_chk = 0;
  int n_err = 0;
  int live_m [3];
  int peak_m [3];

  always #5 clk = ~clk;

  seg7_value_display #(.DATA_W(16), .CHANNELS(3), .DIGITS(6), .REFRESH_DIV(32), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .sample_data(sample_data), .sample_valid(sample_valid),
    .chan_sel(chan_sel), .peak_mode(peak_mode), .peak_clr(peak_clr), .hex(hex),
    .refresh_pulse(refresh_pulse), .busy(busy), .overflow(overflow)
  );

  seg7_value_display #(.DATA_W(16), .CHANNELS(3), .DIGITS(4), .REFRESH_DIV(32), .ACTIVE_LOW(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample_data(d4_data), .sample_valid(d4_valid),
    .chan_sel(d4_sel), .peak_mode(d4_pmode), .peak_clr(d4_pclr), .hex(d4_hex),
    .refresh_pulse(d4_pulse), .busy(d4_busy), .overflow(d4_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Decimal rendering straight from the display rules: digits, sign slot, overflow.
  function automatic void exp_disp(input int v, input int nd, output logic [47:0] h, output logic ov);
    int mag, lim, t;
    bit placed;
    h = '1;
    mag = iabs(v);
    lim = 1;
    for (int i = 0; i < nd - 1; i++) lim = lim * 10;
    ov = (mag >= lim);
    if (ov) begin
      for (int i = 0; i < nd; i++) h[i*8 +: 8] = 8'hBF;
      return;
    end
    t = mag;
    placed = 1'b0;
    for (int i = 0; i < nd - 1; i++) begin
      if (i == 0 || t != 0) begin
        h[i*8 +: 8] = seg_of(t % 10);
        t = t / 10;
      end else if (v < 0 && !placed) begin
        h[i*8 +: 8] = 8'hBF;
        placed = 1'b1;
      end
    end
    if (v < 0 && !placed) h[(nd-1)*8 +: 8] = 8'hBF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input int s0, input int s1, input int s2, input bit clr);
    int s [3];
    s[0] = s0; s[1] = s1; s[2] = s2;
    sample_data  = {16'(s2), 16'(s1), 16'(s0)};
    sample_valid = 1'b1;
    peak_clr     = clr;
    for (int k = 0; k < 3; k++) begin
      if (clr) peak_m[k] = 0;
      live_m[k] = s[k];
      if (iabs(s[k]) > iabs(peak_m[k])) peak_m[k] = s[k];
    end
  endtask

  task automatic send(input int s0, input int s1, input int s2, input bit clr);
    drive_sample(s0, s1, s2, clr);
    tick();
    sample_valid = 1'b0;
    peak_clr     = 1'b0;
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      if (refresh_pulse) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic show(input string tag, input bit disturb);
    bit ok;
    int sel, v, bad;
    logic [47:0] eh, old;
    logic eo;
    wait_pulse(ok);
    check({tag, "_pulse"}, 64'(ok), 64'd1);
    sel = (chan_sel < 2'd3) ? int'(chan_sel) : 0;
    v = peak_mode ? peak_m[sel] : live_m[sel];
    exp_disp(v, 6, eh, eo);
    old = hex;
    bad = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (!busy || hex !== old) bad++;
      if (disturb && i == 3) begin
        chan_sel = chan_sel + 2'd1;
        drive_sample(rnd16(), rnd16(), rnd16(), 1'b0);
      end
      if (disturb && i == 4) sample_valid = 1'b0;
    end
    check({tag, "_busy_window"}, 64'(bad), 64'd0);
    tick();
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_hex"}, 64'(hex), 64'(eh));
    check({tag, "_ovf"}, 64'(overflow), 64'(eo));
  endtask

  task automatic d4_show(input string tag, input int v);
    int n;
    logic [47:0] eh;
    logic eo;
    d4_data  = {32'd0, 16'(v)};
    d4_valid = 1'b1;
    tick();
    d4_valid = 1'b0;
    n = 0;
    while (!d4_pulse && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_pulse"}, 64'(d4_pulse), 64'd1);
    repeat (18) tick();
    exp_disp(v, 4, eh, eo);
    check({tag, "_hex"}, 64'(d4_hex), 64'(eh[31:0]));
    check({tag, "_ovf"}, 64'(d4_ovf), 64'(eo));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, bad;
    bit ok;
    rst_n = 1'b0; sample_data = '0; sample_valid = 1'b0; chan_sel = '0;
    peak_mode = 1'b0; peak_clr = 1'b0;
    d4_data = '0; d4_valid = 1'b0; d4_sel = '0; d4_pmode = 1'b0; d4_pclr = 1'b0;
    for (int i = 0; i < 3; i++) begin live_m[i] = 0; peak_m[i] = 0; end
    repeat (5) tick();
    check("reset_hex", 64'(hex), 64'hFFFF_FFFF_FFFF);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_pulse", 64'(refresh_pulse), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);
    check("reset_hex4", 64'(d4_hex), 64'hFFFF_FFFF);

    rst_n = 1'b1;
    k = 1;
    while (!refresh_pulse && k < 100) begin
      tick();
      k++;
    end
    check("first_pulse_cycle", 64'(k), 64'd32);
    bad = 0;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (refresh_pulse !== ((c % 32) == 0)) bad++;
    end
    check("pulse_period", 64'(bad), 64'd0);

    chan_sel = 2'd0; peak_mode = 1'b0;
    send(256, 0, 0, 1'b0);
    show("ch0_256", 1'b0);
    check("ch0_256_const", 64'(hex), 64'hFFFF_FFA4_9282);

    chan_sel = 2'd1;
    send(0, -32768, 0, 1'b0);
    show("ch1_min", 1'b0);
    check("ch1_min_const", 64'(hex), 64'hBFB0_A4F8_8280);
    send(0, -5, 0, 1'b0);
    show("ch1_m5", 1'b0);
    check("ch1_m5_const", 64'(hex), 64'hFFFF_FFFF_BF92);
    send(0, 0, 0, 1'b0);
    show("ch1_zero", 1'b0);
    check("ch1_zero_const", 64'(hex), 64'hFFFF_FFFF_FFC0);

    send(0, 0, 100, 1'b0);
    send(0, 0, -300, 1'b0);
    send(0, 0, 200, 1'b0);
    chan_sel = 2'd2; peak_mode = 1'b1;
    show("peak_m300", 1'b0);
    check("peak_m300_const", 64'(hex), 64'hFFFF_BFB0_C0C0);
    send(0, 0, 7, 1'b1);
    show("peak_clr7", 1'b0);
    check("peak_clr7_const", 64'(hex), 64'hFFFF_FFFF_FFF8);

    chan_sel = 2'd0; peak_mode = 1'b0;
    send(1234, -77, 9, 1'b0);
    show("disturb", 1'b1);

    for (int r = 0; r < 10; r++) begin
      chan_sel  = 2'($urandom_range(0, 3));
      peak_mode = 1'($urandom_range(0, 1));
      send(rnd16(), rnd16(), rnd16(), ($urandom_range(0, 3) == 0));
      show("rand", 1'b0);
    end

    wait_pulse(ok);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("midshift_rst_hex", 64'(hex), 64'hFFFF_FFFF_FFFF);
    check("midshift_rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin live_m[i] = 0; peak_m[i] = 0; end
    chan_sel = 2'd0; peak_mode = 1'b0;
    show("post_rst", 1'b0);

    d4_show("d4_1000", 1000);
    check("d4_1000_const", 64'(d4_hex), 64'hBFBF_BFBF);
    d4_show("d4_999", 999);
    check("d4_999_const", 64'(d4_hex), 64'hFF90_9090);
    d4_show("d4_m999", -999);
    check("d4_m999_const", 64'(d4_hex), 64'hBF90_9090);
    for (int r = 0; r < 4; r++) d4_show("d4_rand", int'($urandom_range(0, 24000)) - 12000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
